// File: rtl/cnn_pkg.sv
// Shared types, widths and arithmetic helpers for the CNN datapath blocks.
package cnn_pkg;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        MAC,
        STORE,
        FINISH
    } conv_state_t;

    localparam acc_t SAT_MAX = 40'sd32767;
    localparam acc_t SAT_MIN = -40'sd32768;

    function automatic data_t sat16(input acc_t a);
        if (a > SAT_MAX)
            return 16'sh7FFF;
        else if (a < SAT_MIN)
            return 16'sh8000;
        else
            return data_t'(a[DATA_W-1:0]);
    endfunction

    function automatic data_t relu(input data_t d);
        return d[DATA_W-1] ? data_t'(0) : d;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Time-shared multiply-accumulate: 16x16 signed product into a 40-bit accumulator.
module mac_unit
    import cnn_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  acc_t  load_val,
    input  logic  en,
    input  data_t a,
    input  data_t b,
    output acc_t  acc
);

    logic signed [2*DATA_W-1:0] w_prod;
    acc_t                       r_acc;

    assign w_prod = a * b;

    // load has priority so a new pixel always starts from its bias
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_acc <= '0;
        else if (load)
            r_acc <= load_val;
        else if (en)
            r_acc <= r_acc + acc_t'(w_prod);
    end

    assign acc = r_acc;

endmodule

// File: rtl/conv2d_engine.sv
// Sequential valid 2D convolution, one output pixel per K*K+2 cycles through a shared MAC.
module conv2d_engine
    import cnn_pkg::*;
#(
    parameter int IN_SIZE     = 6,
    parameter int K_SIZE      = 3,
    parameter int NUM_FILTERS = 3,
    parameter int FRAC_BITS   = 0,
    parameter int RELU_EN     = 1,
    localparam int OUT_SIZE   = IN_SIZE - K_SIZE + 1
)
(
    input  logic  clk,
    input  logic  reset,
    input  logic  start,
    input  data_t image       [IN_SIZE*IN_SIZE],
    input  data_t weights     [K_SIZE*K_SIZE*NUM_FILTERS],
    input  data_t bias        [NUM_FILTERS],
    output data_t conv_result [OUT_SIZE*OUT_SIZE*NUM_FILTERS],
    output logic  busy,
    output logic  done
);

    localparam int N_IMG = IN_SIZE * IN_SIZE;
    localparam int N_WTS = K_SIZE * K_SIZE * NUM_FILTERS;
    localparam int N_OUT = OUT_SIZE * OUT_SIZE * NUM_FILTERS;

    localparam int F_W    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int O_W    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int K_W    = (K_SIZE > 1) ? $clog2(K_SIZE) : 1;
    localparam int IMG_AW = (N_IMG > 1) ? $clog2(N_IMG) : 1;
    localparam int WTS_AW = (N_WTS > 1) ? $clog2(N_WTS) : 1;
    localparam int OUT_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [F_W-1:0] F_LAST = F_W'(NUM_FILTERS - 1);
    localparam logic [O_W-1:0] O_LAST = O_W'(OUT_SIZE - 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(K_SIZE - 1);

    conv_state_t r_state;
    conv_state_t w_state_next;

    logic [F_W-1:0] r_f;
    logic [O_W-1:0] r_r;
    logic [O_W-1:0] r_c;
    logic [K_W-1:0] r_kr;
    logic [K_W-1:0] r_kc;
    logic           r_done;
    data_t          r_conv_result [N_OUT];

    logic              w_mac_load;
    logic              w_mac_en;
    logic              w_store_en;
    logic              w_last_tap;
    logic              w_last_pixel;
    logic [IMG_AW-1:0] w_img_idx;
    logic [WTS_AW-1:0] w_wts_idx;
    logic [OUT_AW-1:0] w_out_idx;
    acc_t              w_load_val;
    acc_t              w_acc;
    acc_t              w_shifted;
    data_t             w_sat;
    data_t             w_store_val;

    assign w_last_tap   = (r_kr == K_LAST) && (r_kc == K_LAST);
    assign w_last_pixel = (r_f == F_LAST) && (r_r == O_LAST) && (r_c == O_LAST);

    always_comb begin
        w_img_idx = IMG_AW'((int'(r_r) + int'(r_kr)) * IN_SIZE + int'(r_c) + int'(r_kc));
        w_wts_idx = WTS_AW'(int'(r_f) * K_SIZE * K_SIZE + int'(r_kr) * K_SIZE + int'(r_kc));
        w_out_idx = OUT_AW'(int'(r_f) * OUT_SIZE * OUT_SIZE + int'(r_r) * OUT_SIZE + int'(r_c));
    end

    assign w_load_val = acc_t'(bias[r_f]) <<< FRAC_BITS;

    mac_unit u_mac (
        .clk      (clk),
        .reset    (reset),
        .load     (w_mac_load),
        .load_val (w_load_val),
        .en       (w_mac_en),
        .a        (image[w_img_idx]),
        .b        (weights[w_wts_idx]),
        .acc      (w_acc)
    );

    // Rescale, saturate, then rectify: ReLU must see the clipped value
    assign w_shifted   = w_acc >>> FRAC_BITS;
    assign w_sat       = sat16(w_shifted);
    assign w_store_val = (RELU_EN != 0) ? relu(w_sat) : w_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_mac_load   = 1'b0;
        w_mac_en     = 1'b0;
        w_store_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start)
                    w_state_next = INIT;
            end
            INIT: begin
                w_mac_load   = 1'b1;
                w_state_next = MAC;
            end
            MAC: begin
                w_mac_en = 1'b1;
                if (w_last_tap)
                    w_state_next = STORE;
            end
            STORE: begin
                w_store_en   = 1'b1;
                w_state_next = w_last_pixel ? FINISH : INIT;
            end
            FINISH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Pixel counters advance c, then r, then f; tap counters kc, then kr
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_f  <= '0;
            r_r  <= '0;
            r_c  <= '0;
            r_kr <= '0;
            r_kc <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_f <= '0;
                        r_r <= '0;
                        r_c <= '0;
                    end
                end
                INIT: begin
                    r_kr <= '0;
                    r_kc <= '0;
                end
                MAC: begin
                    if (r_kc == K_LAST) begin
                        r_kc <= '0;
                        if (r_kr != K_LAST)
                            r_kr <= r_kr + 1'b1;
                    end else begin
                        r_kc <= r_kc + 1'b1;
                    end
                end
                STORE: begin
                    if (r_c == O_LAST) begin
                        r_c <= '0;
                        if (r_r == O_LAST) begin
                            r_r <= '0;
                            r_f <= (r_f == F_LAST) ? '0 : r_f + 1'b1;
                        end else begin
                            r_r <= r_r + 1'b1;
                        end
                    end else begin
                        r_c <= r_c + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_OUT; i++)
                r_conv_result[i] <= '0;
        end else if (w_store_en) begin
            r_conv_result[w_out_idx] <= w_store_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_done <= 1'b0;
        else
            r_done <= (r_state == FINISH);
    end

    assign conv_result = r_conv_result;
    assign busy        = (r_state != IDLE);
    assign done        = r_done;

endmodule

// File: tb/tb_conv2d_engine.sv
// Directed and randomized checks of conv2d_engine, ReLU and signed variants side by side.
module tb_conv2d_engine;
    import cnn_pkg::*;

    localparam int IN   = 6;
    localparam int K    = 3;
    localparam int NF   = 3;
    localparam int OUT  = IN - K + 1;
    localparam int NOUT = OUT * OUT * NF;
    localparam int FRAC = 0;
    localparam int LAT  = NOUT * (K * K + 2) + 1;

    logic  clk;
    logic  rst;
    logic  start;
    data_t img   [IN*IN];
    data_t wts   [K*K*NF];
    data_t bs    [NF];
    data_t res_r [NOUT];
    data_t res_n [NOUT];
    logic  busy_r, done_r, busy_n, done_n;

    int n_checks = 0;
    int n_pass   = 0;

    conv2d_engine #(.IN_SIZE(IN), .K_SIZE(K), .NUM_FILTERS(NF), .FRAC_BITS(FRAC), .RELU_EN(1)) dut_relu (
        .clk(clk), .reset(rst), .start(start), .image(img), .weights(wts), .bias(bs),
        .conv_result(res_r), .busy(busy_r), .done(done_r)
    );

    conv2d_engine #(.IN_SIZE(IN), .K_SIZE(K), .NUM_FILTERS(NF), .FRAC_BITS(FRAC), .RELU_EN(0)) dut_lin (
        .clk(clk), .reset(rst), .start(start), .image(img), .weights(wts), .bias(bs),
        .conv_result(res_n), .busy(busy_n), .done(done_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: direct sum over the kernel window, then shift, clip and optional rectify
    function automatic longint model(input int relu_on, input int f, input int r, input int c);
        longint acc;
        acc = longint'(bs[f]) * (longint'(1) << FRAC);
        for (int kr = 0; kr < K; kr++)
            for (int kc = 0; kc < K; kc++)
                acc += longint'(img[(r + kr) * IN + c + kc]) * longint'(wts[f * K * K + kr * K + kc]);
        acc = acc >>> FRAC;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        if (relu_on != 0 && acc < 0) acc = 0;
        return acc;
    endfunction

    task automatic check_model(input string tag);
        for (int f = 0; f < NF; f++)
            for (int r = 0; r < OUT; r++)
                for (int c = 0; c < OUT; c++) begin
                    chk({tag, "_relu"}, res_r[f*OUT*OUT + r*OUT + c], model(1, f, r, c));
                    chk({tag, "_lin"},  res_n[f*OUT*OUT + r*OUT + c], model(0, f, r, c));
                end
    endtask

    task automatic fill(input int iv, input int wv, input int bv);
        foreach (img[i]) img[i] = data_t'(iv);
        foreach (wts[i]) wts[i] = data_t'(wv);
        foreach (bs[i])  bs[i]  = data_t'(bv);
    endtask

    // One run from start acceptance to done; optional stray start pulse at cycle 'glitch'
    task automatic run(input string tag, input int glitch);
        int cyc;
        int busy_cnt;
        int done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        busy_cnt = busy_r ? 1 : 0;
        while (!done_r && cyc < 2 * LAT) begin
            start = (cyc == glitch);
            tick();
            cyc++;
            if (!done_r && busy_r) busy_cnt++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, cyc, LAT);
        chk({tag, "_busy_at_done"}, busy_r, 0);
        chk({tag, "_busy_cycles"}, busy_cnt, LAT);
        chk({tag, "_lin_done"}, done_n, 1);
        done_cnt = done_r ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done_r) done_cnt++;
        end
        chk({tag, "_done_pulses"}, done_cnt, 1);
    endtask

    initial begin
        int first_done;
        int second_done;
        int cyc;
        logic signed [63:0] pmax;

        rst = 1'b1;
        start = 1'b0;
        fill(0, 0, 0);
        tick();
        tick();
        chk("reset_busy", busy_r, 0);
        chk("reset_done", done_r, 0);
        for (int i = 0; i < NOUT; i++) chk("reset_result", res_r[i], 0);
        rst = 1'b0;
        tick();

        // Test 1: all ones
        fill(1, 1, 0);
        run("ones", -1);
        for (int i = 0; i < NOUT; i++) begin
            chk("ones_relu", res_r[i], 9);
            chk("ones_lin", res_n[i], 9);
        end

        // Test 2: addressing order
        fill(0, 0, 0);
        foreach (img[i]) img[i] = data_t'(i);
        wts[0] = 16'sd1;
        run("index", -1);
        for (int r = 0; r < OUT; r++)
            for (int c = 0; c < OUT; c++)
                chk("index_f0", res_r[r*OUT + c], r * IN + c);
        for (int pr = 0; pr < 2; pr++)
            for (int pc = 0; pc < 2; pc++) begin
                pmax = -32768;
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (res_r[(2*pr + dr)*OUT + 2*pc + dc] > pmax)
                            pmax = res_r[(2*pr + dr)*OUT + 2*pc + dc];
                chk("pool_f0", pmax, (pr == 0) ? ((pc == 0) ? 7 : 9) : ((pc == 0) ? 19 : 21));
            end

        // Test 3: sign, bias and ReLU; stray start at cycle 100 must be ignored
        fill(1, 0, 0);
        for (int i = 0; i < K*K; i++) wts[K*K + i] = -16'sd1;
        bs[1] = 16'sd5;
        bs[2] = 16'sd100;
        run("sign", 100);
        for (int i = 0; i < OUT*OUT; i++) begin
            chk("bias_neg_relu", res_r[OUT*OUT + i], 0);
            chk("bias_neg_lin", res_n[OUT*OUT + i], -4);
            chk("bias_only_relu", res_r[2*OUT*OUT + i], 100);
            chk("bias_only_lin", res_n[2*OUT*OUT + i], 100);
        end

        // Test 4: saturation both ways
        fill(32767, 32767, 0);
        run("sat_pos", -1);
        for (int i = 0; i < NOUT; i += 5) chk("sat_pos_lin", res_n[i], 32767);
        fill(32767, -32768, 0);
        run("sat_neg", -1);
        for (int i = 0; i < NOUT; i += 5) begin
            chk("sat_neg_lin", res_n[i], -32768);
            chk("sat_neg_relu", res_r[i], 0);
        end

        // Test 5: start held high -> back-to-back runs one idle cycle apart
        fill(1, 1, 0);
        start = 1'b1;
        tick();
        cyc = 0;
        first_done = -1;
        second_done = -1;
        while (second_done < 0 && cyc < 3 * LAT) begin
            tick();
            cyc++;
            if (done_r) begin
                if (first_done < 0) first_done = cyc;
                else second_done = cyc;
            end
        end
        start = 1'b0;
        chk("held_first_done", first_done, LAT);
        chk("held_second_done", second_done, 2 * LAT + 1);
        for (int i = 0; i < 5; i++) tick();
        chk("held_idle_after", busy_r, 0);

        // Test 6: reset mid-run clears everything; a fresh run is fully correct
        fill(32767, 32767, 0);
        run("pre_reset", -1);
        fill(1, 1, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200; i++) tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy_r, 0);
        chk("midrst_done", done_r, 0);
        for (int i = 0; i < NOUT; i++) chk("midrst_result", res_n[i], 0);
        tick();
        rst = 1'b0;
        tick();
        run("after_reset", -1);
        for (int i = 0; i < NOUT; i++) chk("after_reset_ones", res_r[i], 9);

        // Randomized runs: full-range and small-magnitude operands
        for (int t = 0; t < 4; t++) begin
            foreach (img[i]) img[i] = (t[0]) ? data_t'($urandom_range(0, 65535)) : data_t'(int'($urandom_range(0, 31)) - 16);
            foreach (wts[i]) wts[i] = (t[0]) ? data_t'($urandom_range(0, 65535)) : data_t'(int'($urandom_range(0, 15)) - 8);
            foreach (bs[i])  bs[i]  = data_t'(int'($urandom_range(0, 400)) - 200);
            run("rand", -1);
            check_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
